branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- 2-way set-associative branch target buffer, looked up with the fetch PC in parallel with the direction predictor.
- Supplies a predicted target address, registered into the decode stage.
- The decode-stage next-PC logic redirects fetch when the direction predictor's pred_takeD is high and btb_hitD is high.
- Trained from the memory stage with resolved branch outcomes and targets.

Parameters:
- IDX_BITS, 6, set index width; 2^IDX_BITS sets, index = pc[IDX_BITS+1:2].
- TAG_BITS, derived as 30-IDX_BITS (localparam); tag = pc[31:IDX_BITS+2].

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flushD  input  1  clear decode-stage output registers
- stallD  input  1  hold decode-stage output registers
- pcF  input  32  fetch-stage PC (lookup address)
- pcM  input  32  memory-stage PC of the resolved instruction
- branchM  input  1  memory-stage instruction is a conditional branch
- actual_takeM  input  1  resolved branch direction
- branch_targetM  input  32  resolved branch target address
- btb_hitF  output  1  combinational lookup hit for pcF
- btb_targetF  output  32  combinational target for pcF; 0 on miss
- btb_hitD  output  1  registered hit for the instruction now in decode
- btb_targetD  output  32  registered target for the instruction now in decode

Behaviour:
- Storage, per set and way: valid (1), tag (TAG_BITS), target (30 bits, word address; the low 2 bits are implied 00). One LRU bit per set: 0 means way0 is least recently used, 1 means way1 is.
- Reset (clk edge with rst=1):
  - all valid bits cleared and all LRU bits cleared;
  - btb_hitD=0, btb_targetD=0;
  - tags and targets need not be reset.
  - Reset mid-operation discards all entries; rst overrides any simultaneous update.
- Lookup (combinational):
  - way w hits when valid[w] and tag[w] == tag(pcF).
  - btb_hitF = OR of the way hits.
  - btb_targetF = {target of the hit way, 2'b00}, or 32'h0 on miss.
  - Both ways hitting is illegal and cannot arise by construction (see allocation). If it does occur, way0 wins.
- Decode registers: priority rst > flushD > stallD.
  - flushD=1: btb_hitD<=0, btb_targetD<=0.
  - stallD=1 (no flush): hold.
  - Otherwise: capture btb_hitF and btb_targetF.
  - Latency pcF -> D outputs: 1 cycle.
- Update, when branchM=1 and actual_takeM=1 at the clk edge:
  - If pcM hits way w in its set: overwrite target[w] with branch_targetM[31:2]; LRU set to point at the other way.
  - On miss, choose the victim as follows:
    - first invalid way, way0 preferred;
    - if both ways are valid, the way named by LRU.
  - Write valid=1, tag(pcM), target into the victim; LRU set to point at the other way.
- When branchM=1 and actual_takeM=0: no change to entries or LRU; a not-taken branch keeps its target.
- When branchM=0: no table change.
- Lookups do not modify LRU.
- Simultaneous update and lookup in the same set, same cycle: the lookup sees pre-update contents (read-old). The new entry is visible from the next cycle.
- Index/tag wrap-around: PCs differing only above bit IDX_BITS+1 map to the same set and are distinguished by tag only.
- No X may propagate to btb_hitF/btb_hitD after reset, even with tags and targets unreset; lookup hit requires valid.

Test Plan:
- Reset, then pcF=0x00400010 -> btb_hitF=0, btb_targetF=0; next edge btb_hitD=0, btb_targetD=0.
- Update pcM=0x00400010, branchM=1, actual_takeM=1, branch_targetM=0x00400100; next cycle pcF=0x00400010 -> btb_hitF=1, btb_targetF=0x00400100; one cycle later btb_hitD=1, btb_targetD=0x00400100.
- Same-set conflict (IDX_BITS=6):
  - Train taken 0x00400010, then 0x00401010 (way1), then 0x00402010 -> the victim is way0 (LRU). 0x00400010 misses; 0x00401010 and 0x00402010 both hit with their targets.
  - Retraining 0x00401010 with target 0x00409000 updates in place, with no new allocation.
- Update with actual_takeM=0 for a present entry, and branchM=0 with actual_takeM=1 -> contents and hit unchanged.
- Lookup pcF=pcM=0x00400020 in the same cycle as its first allocation -> btb_hitF=0 that cycle, 1 the next cycle.
- Holding btb_hitD=1 with stallD=1 for 3 cycles -> btb_hitD and btb_targetD unchanged. Then flushD=1 together with stallD=1 -> btb_hitD=0, btb_targetD=0 at the next edge. Then rst with the table populated -> all lookups miss.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// Fetch/decode/memory-stage signal bundle for the branch target buffer.
interface branch_target_buffer_if;
    logic        flushD;
    logic        stallD;
    logic [31:0] pcF;
    logic [31:0] pcM;
    logic        branchM;
    logic        actual_takeM;
    logic [31:0] branch_targetM;
    logic        btb_hitF;
    logic [31:0] btb_targetF;
    logic        btb_hitD;
    logic [31:0] btb_targetD;

    // Pipeline side: drives lookup/train requests, consumes predictions.
    modport master (
        output flushD, stallD, pcF, pcM, branchM, actual_takeM, branch_targetM,
        input  btb_hitF, btb_targetF, btb_hitD, btb_targetD
    );

    // BTB side.
    modport slave (
        input  flushD, stallD, pcF, pcM, branchM, actual_takeM, branch_targetM,
        output btb_hitF, btb_targetF, btb_hitD, btb_targetD
    );
endinterface

// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer with one LRU bit per set.
// Lookup is combinational on pcF and registered into decode; training
// happens from the memory stage on taken branches only.
module branch_target_buffer #(
    parameter int IDX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_target_buffer_if.slave bus
);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int SETS     = 1 << IDX_BITS;

    // Only valid and LRU need a reset; tags/targets are qualified by valid.
    logic [SETS-1:0]     valid0_q, valid0_d;
    logic [SETS-1:0]     valid1_q, valid1_d;
    logic [SETS-1:0]     lru_q, lru_d;
    logic [TAG_BITS-1:0] tag0_q [SETS];
    logic [TAG_BITS-1:0] tag1_q [SETS];
    logic [29:0]         tgt0_q [SETS];
    logic [29:0]         tgt1_q [SETS];

    logic                hitD_q, hitD_d;
    logic [31:0]         targetD_q, targetD_d;

    logic [IDX_BITS-1:0] idx_f, idx_m;
    logic [TAG_BITS-1:0] tag_f, tag_m;
    logic                hit0_f, hit1_f;
    logic                hit0_m, hit1_m;
    logic                upd;
    logic                way_m;

    // Word-offset bits of the PCs/target never matter to the table.
    logic unused_low_bits;
    assign unused_low_bits = ^{bus.pcF[1:0], bus.pcM[1:0], bus.branch_targetM[1:0]};

    assign idx_f = bus.pcF[IDX_BITS+1:2];
    assign tag_f = bus.pcF[31:IDX_BITS+2];
    assign idx_m = bus.pcM[IDX_BITS+1:2];
    assign tag_m = bus.pcM[31:IDX_BITS+2];
    assign upd   = bus.branchM & bus.actual_takeM;

    // Fetch lookup; valid gates the compare so unreset tags can never leak X.
    always_comb begin
        hit0_f          = valid0_q[idx_f] && (tag0_q[idx_f] == tag_f);
        hit1_f          = valid1_q[idx_f] && (tag1_q[idx_f] == tag_f);
        bus.btb_hitF    = hit0_f | hit1_f;
        bus.btb_targetF = 32'h0;
        if (hit0_f) begin
            bus.btb_targetF = {tgt0_q[idx_f], 2'b00};
        end else if (hit1_f) begin
            bus.btb_targetF = {tgt1_q[idx_f], 2'b00};
        end
    end

    // Training: pick the way to write (hit way, else first invalid, else LRU).
    always_comb begin
        hit0_m   = valid0_q[idx_m] && (tag0_q[idx_m] == tag_m);
        hit1_m   = valid1_q[idx_m] && (tag1_q[idx_m] == tag_m);
        valid0_d = valid0_q;
        valid1_d = valid1_q;
        lru_d    = lru_q;
        if (hit0_m) begin
            way_m = 1'b0;
        end else if (hit1_m) begin
            way_m = 1'b1;
        end else if (!valid0_q[idx_m]) begin
            way_m = 1'b0;
        end else if (!valid1_q[idx_m]) begin
            way_m = 1'b1;
        end else begin
            way_m = lru_q[idx_m];
        end
        if (upd) begin
            if (way_m) begin
                valid1_d[idx_m] = 1'b1;
            end else begin
                valid0_d[idx_m] = 1'b1;
            end
            lru_d[idx_m] = ~way_m;
        end
    end

    // Valid and LRU state with reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            lru_q    <= lru_d;
        end
    end

    // Tag/target storage, written on taken-branch training only.
    always_ff @(posedge clk) begin
        if (upd && !rst) begin
            if (way_m) begin
                tag1_q[idx_m] <= tag_m;
                tgt1_q[idx_m] <= bus.branch_targetM[31:2];
            end else begin
                tag0_q[idx_m] <= tag_m;
                tgt0_q[idx_m] <= bus.branch_targetM[31:2];
            end
        end
    end

    // Decode-stage next value: flush clears, stall holds, else capture lookup.
    always_comb begin
        hitD_d    = bus.btb_hitF;
        targetD_d = bus.btb_targetF;
        if (bus.flushD) begin
            hitD_d    = 1'b0;
            targetD_d = 32'h0;
        end else if (bus.stallD) begin
            hitD_d    = hitD_q;
            targetD_d = targetD_q;
        end
    end

    // Decode-stage prediction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hitD_q    <= 1'b0;
            targetD_q <= 32'h0;
        end else begin
            hitD_q    <= hitD_d;
            targetD_q <= targetD_d;
        end
    end

    assign bus.btb_hitD    = hitD_q;
    assign bus.btb_targetD = targetD_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with hand-computed expectations.
module tb_branch_target_buffer;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    branch_target_buffer_if bus ();

    branch_target_buffer #(.IDX_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic hit, input logic [31:0] tgt);
        bus.pcF = pc;
        #1;
        check_eq({tag, "_hitF"}, {31'b0, bus.btb_hitF}, {31'b0, hit});
        check_eq({tag, "_tgtF"}, bus.btb_targetF, tgt);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic br, input logic take);
        bus.pcM            = pc;
        bus.branch_targetM = tgt;
        bus.branchM        = br;
        bus.actual_takeM   = take;
        tick();
        bus.branchM      = 1'b0;
        bus.actual_takeM = 1'b0;
    endtask

    task automatic check_d(input string tag, input logic hit, input logic [31:0] tgt);
        check_eq({tag, "_hitD"}, {31'b0, bus.btb_hitD}, {31'b0, hit});
        check_eq({tag, "_tgtD"}, bus.btb_targetD, tgt);
    endtask

    initial begin
        n_total            = 0;
        n_pass             = 0;
        rst                = 1'b1;
        bus.flushD         = 1'b0;
        bus.stallD         = 1'b0;
        bus.pcF            = 32'h0;
        bus.pcM            = 32'h0;
        bus.branchM        = 1'b0;
        bus.actual_takeM   = 1'b0;
        bus.branch_targetM = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_d("rst", 1'b0, 32'h0);
        lookup("rst_miss", 32'h0040_0010, 1'b0, 32'h0);
        tick();
        check_d("rst_miss", 1'b0, 32'h0);

        // First allocation, lookup next cycle, decode one cycle later
        train(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b1);
        lookup("alloc", 32'h0040_0010, 1'b1, 32'h0040_0100);
        tick();
        check_d("alloc", 1'b1, 32'h0040_0100);

        // Same-set conflict: A->way0, B->way1, C evicts way0 (A)
        train(32'h0040_1010, 32'h0040_5000, 1'b1, 1'b1);
        train(32'h0040_2010, 32'h0040_6000, 1'b1, 1'b1);
        lookup("evictA", 32'h0040_0010, 1'b0, 32'h0);
        lookup("keepB",  32'h0040_1010, 1'b1, 32'h0040_5000);
        lookup("newC",   32'h0040_2010, 1'b1, 32'h0040_6000);

        // Retrain B in place; C must survive, and LRU now names C's way
        train(32'h0040_1010, 32'h0040_9000, 1'b1, 1'b1);
        lookup("retrB", 32'h0040_1010, 1'b1, 32'h0040_9000);
        lookup("retrC", 32'h0040_2010, 1'b1, 32'h0040_6000);

        // Not-taken and non-branch updates leave contents alone
        train(32'h0040_1010, 32'h1111_1110, 1'b1, 1'b0);
        lookup("ntB", 32'h0040_1010, 1'b1, 32'h0040_9000);
        train(32'h0040_1010, 32'h2222_2220, 1'b0, 1'b1);
        lookup("nbB", 32'h0040_1010, 1'b1, 32'h0040_9000);
        train(32'h0040_3010, 32'h3333_3330, 1'b0, 1'b1);
        lookup("nbNew", 32'h0040_3010, 1'b0, 32'h0);
        lookup("nbC", 32'h0040_2010, 1'b1, 32'h0040_6000);

        // Re-allocate A: the retrain of B made C's way the LRU victim
        train(32'h0040_0010, 32'h0040_7000, 1'b1, 1'b1);
        lookup("lruA", 32'h0040_0010, 1'b1, 32'h0040_7000);
        lookup("lruC", 32'h0040_2010, 1'b0, 32'h0);
        lookup("lruB", 32'h0040_1010, 1'b1, 32'h0040_9000);

        // Lookup of the same PC in its allocation cycle sees old contents
        bus.pcM            = 32'h0040_0020;
        bus.branch_targetM = 32'h0040_0300;
        bus.branchM        = 1'b1;
        bus.actual_takeM   = 1'b1;
        lookup("rdold", 32'h0040_0020, 1'b0, 32'h0);
        tick();
        bus.branchM      = 1'b0;
        bus.actual_takeM = 1'b0;
        lookup("rdnew", 32'h0040_0020, 1'b1, 32'h0040_0300);

        // Stall holds decode registers while fetch changes to a miss
        tick();
        check_d("pre_stall", 1'b1, 32'h0040_0300);
        bus.stallD = 1'b1;
        bus.pcF    = 32'h0040_0040;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_d("stall", 1'b1, 32'h0040_0300);
        end
        bus.flushD = 1'b1;
        tick();
        check_d("flush", 1'b0, 32'h0);
        bus.flushD = 1'b0;
        bus.stallD = 1'b0;

        // Reset with a populated table and a simultaneous update
        bus.pcF = 32'h0040_0020;
        tick();
        check_d("pre_rst", 1'b1, 32'h0040_0300);
        rst                = 1'b1;
        bus.pcM            = 32'h0040_0040;
        bus.branch_targetM = 32'h0040_0800;
        bus.branchM        = 1'b1;
        bus.actual_takeM   = 1'b1;
        tick();
        rst              = 1'b0;
        bus.branchM      = 1'b0;
        bus.actual_takeM = 1'b0;
        check_d("rst2", 1'b0, 32'h0);
        lookup("rst2_C", 32'h0040_0020, 1'b0, 32'h0);
        lookup("rst2_A", 32'h0040_0010, 1'b0, 32'h0);
        lookup("rst2_B", 32'h0040_1010, 1'b0, 32'h0);
        lookup("rst2_upd", 32'h0040_0040, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
